// File: rtl/msrv32_fetch_buffer.sv
// msrv32_fetch_buffer
//   Instruction-fetch unit for the msrv32 core. A DEPTH-entry prefetch FIFO
//   sits between the AHB-lite instruction port and decode, so that memory
//   wait states do not stall decode directly. The unit drops stale fetches
//   on redirects and tags each instruction that returned a bus error.
//
//   Optional feature: define FETCH_BYPASS_EN to let a returning beat reach
//   the head outputs in the same cycle when the FIFO is empty. This
//   shortens redirect-to-valid latency by one cycle.
//
// Ports
//   clock, rst_in          single clock; synchronous active-low reset
//   redirect_in/_addr_in   flush and restart fetch at a new (word-aligned) PC
//   imaddr_out, ireq_out   AHB address phase (NONSEQ when ireq_out=1)
//   instr_in, instr_hready_in, instr_hresp_in   AHB data phase
//   ready_in               decode accepts the head entry
//   valid_out, instr_out, pc_out, fault_out     head entry
//   level_out              number of occupied FIFO entries
//   state_out              debug: 0 = FETCH, 1 = HALT
//
// Handshake: decode pops the head on a cycle with valid_out && ready_in.
// The AHB address phase is accepted on ireq_out && instr_hready_in. The data
// phase of that beat completes on the next cycle that has
// instr_hready_in == 1.
module msrv32_fetch_buffer #(
   parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
   parameter int unsigned DEPTH        = 4
) (
   input  logic                       clock,
   input  logic                       rst_in,
   input  logic                       redirect_in,
   input  logic [31:0]                redirect_addr_in,
   output logic [31:0]                imaddr_out,
   output logic                       ireq_out,
   input  logic [31:0]                instr_in,
   input  logic                       instr_hready_in,
   input  logic                       instr_hresp_in,
   input  logic                       ready_in,
   output logic                       valid_out,
   output logic [31:0]                instr_out,
   output logic [31:0]                pc_out,
   output logic                       fault_out,
   output logic [$clog2(DEPTH):0]     level_out,
   output logic                       state_out
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [PW:0]   lvl_t;
   typedef enum logic {ST_FETCH = 1'b0, ST_HALT = 1'b1} state_t;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } entry_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        inflight_q, inflight_d;   // one data phase outstanding
   logic        stale_q, stale_d;         // that beat belongs to an old stream
   logic [31:0] beat_pc_q, beat_pc_d;
   logic        pend_q, pend_d;           // stalled address phase outlived a redirect
   logic [31:0] pend_pc_q, pend_pc_d;     // target to resume at once it completes
   ptr_t        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   lvl_t        level_q, level_d;
   entry_t      mem_q [DEPTH];
   entry_t      mem_d [DEPTH];

   logic        credit_ok, addr_acc, data_done, beat_live, fifo_empty;
   logic        push, pop, bypass;
   logic [31:0] redir_pc;
   entry_t      beat, head;

   always_comb begin
      fifo_empty = (level_q == '0);
      head       = mem_q[rd_ptr_q];
      redir_pc   = redirect_addr_in & 32'hFFFF_FFFC;
      // Outstanding beats reserve a slot, so a returning beat always fits.
      credit_ok  = (32'(level_q) + 32'(inflight_q)) < DEPTH;
      // A stalled address phase must stay on the bus even after a redirect.
      ireq_out   = rst_in && (pend_q || ((state_q == ST_FETCH) && credit_ok));
      imaddr_out = fetch_pc_q;
      addr_acc   = ireq_out && instr_hready_in;
      data_done  = inflight_q && instr_hready_in;
      beat_live  = data_done && !stale_q && !redirect_in;
      beat.instr = instr_hresp_in ? NOP : instr_in;
      beat.pc    = beat_pc_q;
      beat.fault = instr_hresp_in;

      valid_out  = !fifo_empty;
      instr_out  = fifo_empty ? NOP : head.instr;
      pc_out     = fifo_empty ? BOOT_ADDRESS : head.pc;
      fault_out  = !fifo_empty && head.fault;
      bypass     = 1'b0;
`ifdef FETCH_BYPASS_EN
      if (fifo_empty && beat_live) begin
         valid_out = 1'b1;
         instr_out = beat.instr;
         pc_out    = beat.pc;
         fault_out = beat.fault;
         bypass    = ready_in;   // consumed directly, never stored
      end
`endif
      pop  = !fifo_empty && ready_in && !redirect_in;
      push = beat_live && !bypass;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (redirect_in) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = beat;
            wr_ptr_d        = wr_ptr_q + ptr_t'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);
         level_d = level_q + lvl_t'(push) - lvl_t'(pop);
      end

      state_d = state_q;
      if (redirect_in)                        state_d = ST_FETCH;
      else if (beat_live && instr_hresp_in)   state_d = ST_HALT;

      inflight_d = inflight_q;
      stale_d    = stale_q;
      beat_pc_d  = beat_pc_q;
      fetch_pc_d = fetch_pc_q;
      pend_d     = pend_q;
      pend_pc_d  = pend_pc_q;
      if (data_done) inflight_d = 1'b0;
      if (addr_acc) begin
         inflight_d = 1'b1;
         stale_d    = pend_q;
         beat_pc_d  = fetch_pc_q;
         fetch_pc_d = pend_q ? pend_pc_q : fetch_pc_q + 32'd4;
         pend_d     = 1'b0;
      end
      if (redirect_in) begin
         // Whatever beat is outstanding after this edge belongs to the old stream.
         stale_d = 1'b1;
         if (ireq_out && !instr_hready_in) begin
            pend_d    = 1'b1;
            pend_pc_d = redir_pc;
         end else begin
            pend_d     = 1'b0;
            fetch_pc_d = redir_pc;
         end
      end
   end

   assign level_out = level_q;
   assign state_out = (state_q == ST_HALT);

   always_ff @(posedge clock) begin
      if (!rst_in) begin
         state_q    <= ST_FETCH;
         fetch_pc_q <= BOOT_ADDRESS;
         inflight_q <= 1'b0;
         stale_q    <= 1'b0;
         beat_pc_q  <= BOOT_ADDRESS;
         pend_q     <= 1'b0;
         pend_pc_q  <= BOOT_ADDRESS;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         stale_q    <= stale_d;
         beat_pc_q  <= beat_pc_d;
         pend_q     <= pend_d;
         pend_pc_q  <= pend_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
      end
   end

   // Storage needs no reset: the head outputs are gated by level_q.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

endmodule
